// File: rtl/video_cap_pack.sv
// video_cap_pack: packs SRC_CHN consecutive source beats into one pixel,
// produces x/y coordinates and checks every line and frame against IW/IH.
// Optional feature macro: VIDEO_CAP_STAT_EN adds stat_clr and cap_err_cnt.
module video_cap_pack #(
  parameter int IW        = 640,
  parameter int IH        = 480,
  parameter int SRC_DW    = 8,
  parameter int SRC_CHN   = 3,
  parameter int MSB_FIRST = 1,
  parameter int XW        = 12,
  parameter int YW        = 12
) (
  input  logic                      src_pclk,
  input  logic                      rst_n,
  input  logic                      src_hsync,
  input  logic                      src_vsync,
  input  logic [SRC_DW-1:0]         src_data_out,
  output logic                      cap_hsync,
  output logic                      cap_vsync,
  output logic                      cap_valid,
  output logic [SRC_DW*SRC_CHN-1:0] cap_data_out,
  output logic [XW-1:0]             cap_x,
  output logic [YW-1:0]             cap_y,
  output logic                      cap_line_err,
  output logic                      cap_frame_done,
  output logic                      cap_frame_err
`ifdef VIDEO_CAP_STAT_EN
  ,
  input  logic                      stat_clr,
  output logic [15:0]               cap_err_cnt
`endif
);

  localparam int PW = SRC_DW * SRC_CHN;
  localparam int CW = (SRC_CHN > 1) ? $clog2(SRC_CHN) : 1;
  localparam int SW = (SRC_CHN > 1) ? (PW - SRC_DW) : SRC_DW;
  localparam logic [CW-1:0] CH_LAST = CW'(SRC_CHN - 1);

  logic [CW-1:0]      ch;
  logic [SW-1:0]      beat_q;
  logic [SW-1:0]      shift_d;
  logic [PW-1:0]      pix_d;
  logic [SRC_CHN-1:0] hs_dly;
  logic [SRC_CHN-1:0] vs_dly;
  logic [SRC_CHN:0]   hs_cat;
  logic [SRC_CHN:0]   vs_cat;
  logic               hs_prev;
  logic               vs_prev;
  logic               armed;
  logic               h_rise;
  logic               line_end;
  logic               pix_done;
  logic               line_bad;
  logic               v_rise;
  logic               v_fall;
  logic               frame_line;
  logic [XW-1:0]      x_cnt;
  logic [YW-1:0]      line_cnt;
  logic [YW-1:0]      lines_eff;
  logic               frame_bad;

  // The sync delay lines are SRC_CHN flops deep; the top bit of each
  // concatenation is the registered output, the one below is its next value.
  assign hs_cat    = {hs_dly, src_hsync};
  assign vs_cat    = {vs_dly, src_vsync};
  assign cap_hsync = hs_cat[SRC_CHN];
  assign cap_vsync = vs_cat[SRC_CHN];

  // beat_q holds the SRC_CHN-1 earlier beats; pix_d is the full pixel
  // including the beat arriving this cycle.
  generate
    if (SRC_CHN == 1) begin : g_single
      assign pix_d   = src_data_out;
      assign shift_d = beat_q;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign pix_d   = {beat_q, src_data_out};
      assign shift_d = pix_d[SW-1:0];
    end else begin : g_lsb
      assign pix_d   = {src_data_out, beat_q};
      assign shift_d = pix_d[PW-1:SRC_DW];
    end
  endgenerate

  // Edge detection and the line/frame events they produce this cycle.
  always_comb begin
    h_rise     = src_hsync & ~hs_prev;
    line_end   = ~src_hsync & hs_prev & armed;
    pix_done   = src_hsync & armed & (ch == CH_LAST);
    line_bad   = line_end & ((ch != '0) | (x_cnt != XW'(IW)));
    v_rise     = src_vsync & ~vs_prev;
    v_fall     = ~src_vsync & vs_prev;
    frame_line = line_end & (src_vsync | vs_prev);
    lines_eff  = line_cnt;
    if (frame_line && (line_cnt != '1)) lines_eff = line_cnt + YW'(1);
  end

  // Sync delay lines and previous-cycle copies of the raw syncs.
  always_ff @(posedge src_pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_dly  <= '0;
      vs_dly  <= '0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      hs_dly  <= hs_cat[SRC_CHN-1:0];
      vs_dly  <= vs_cat[SRC_CHN-1:0];
      hs_prev <= src_hsync;
      vs_prev <= src_vsync;
    end
  end

  // Beat counter and beat history; armed means a low hsync has been seen since
  // reset, so a line that was already running at reset is never packed.
  always_ff @(posedge src_pclk or negedge rst_n) begin
    if (!rst_n) begin
      ch     <= '0;
      beat_q <= '0;
      armed  <= 1'b0;
    end else if (!src_hsync) begin
      ch    <= '0;
      armed <= 1'b1;
    end else begin
      ch     <= (ch == CH_LAST) ? '0 : ch + CW'(1);
      beat_q <= shift_d;
    end
  end

  // Pixel strobe and data; data holds while the delayed line is active and
  // is cleared as soon as the delayed line goes inactive.
  always_ff @(posedge src_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid    <= 1'b0;
      cap_data_out <= '0;
    end else begin
      cap_valid <= pix_done;
      if (pix_done) cap_data_out <= pix_d;
      else if (!hs_cat[SRC_CHN-1]) cap_data_out <= '0;
    end
  end

  // Column tracking: x_cnt counts pixels in the line, cap_x labels the pixel.
  always_ff @(posedge src_pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      cap_x <= '0;
    end else if (h_rise) begin
      x_cnt <= pix_done ? XW'(1) : '0;
      cap_x <= '0;
    end else if (pix_done) begin
      cap_x <= x_cnt;
      if (x_cnt != '1) x_cnt <= x_cnt + XW'(1);
    end
  end

  // Line and frame checks, row counter and frame error accumulation.
  always_ff @(posedge src_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cap_line_err   <= 1'b0;
      cap_frame_done <= 1'b0;
      cap_frame_err  <= 1'b0;
      cap_y          <= '0;
      line_cnt       <= '0;
      frame_bad      <= 1'b0;
    end else begin
      cap_line_err   <= line_bad;
      cap_frame_done <= v_fall;
      cap_frame_err  <= v_fall & ((lines_eff != YW'(IH)) | frame_bad | line_bad);
      if (v_rise) begin
        cap_y     <= '0;
        line_cnt  <= '0;
        frame_bad <= 1'b0;
      end else begin
        line_cnt <= lines_eff;
        if (line_bad) frame_bad <= 1'b1;
        if (line_end && src_vsync && (cap_y != '1)) cap_y <= cap_y + YW'(1);
      end
    end
  end

`ifdef VIDEO_CAP_STAT_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, cap_err_cnt} + 17'(cap_line_err) + 17'(cap_frame_err);

  // Saturating error counter; a clear beats a simultaneous increment.
  always_ff @(posedge src_pclk or negedge rst_n) begin
    if (!rst_n) cap_err_cnt <= '0;
    else if (stat_clr) cap_err_cnt <= '0;
    else if (err_sum[16]) cap_err_cnt <= '1;
    else cap_err_cnt <= err_sum[15:0];
  end
`endif

endmodule
